// File: rtl/nram_regfile_mp_if.sv
// nram_regfile_mp_if: write, dual-read and clear bus of the nram_regfile_mp register file
interface nram_regfile_mp_if #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
);
   localparam int AW = $clog2(DEPTH);
   logic [WIDTH-1:0] io_D;
   logic [AW-1:0]    io_WADD;
   logic             io_WEN;
   logic [AW-1:0]    io_RADD_0;
   logic [AW-1:0]    io_RADD_1;
   logic [WIDTH-1:0] io_Q_0;
   logic [WIDTH-1:0] io_Q_1;
   logic             io_QV_0;
   logic             io_QV_1;
   logic             io_CLR;
   logic             io_BUSY;
   logic             io_WERR;
   modport master (
      output io_D, io_WADD, io_WEN, io_RADD_0, io_RADD_1, io_CLR,
      input  io_Q_0, io_Q_1, io_QV_0, io_QV_1, io_BUSY, io_WERR
   );
   modport slave (
      input  io_D, io_WADD, io_WEN, io_RADD_0, io_RADD_1, io_CLR,
      output io_Q_0, io_Q_1, io_QV_0, io_QV_1, io_BUSY, io_WERR
   );
endinterface

// File: rtl/nram_regfile_mp.sv
// nram_regfile_mp: DEPTH x WIDTH register file, one write port, two registered read ports, per-entry valid bits and a hardware clear sequencer; define NRAM_RF_WR_BYPASS_EN for write-through read bypass
module nram_regfile_mp #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input logic clk,
   input logic reset,
   nram_regfile_mp_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   typedef enum logic {IDLE, CLEAR} state_t;
   state_t           state;
   logic [WIDTH-1:0] mem [DEPTH];
   logic [DEPTH-1:0] valid;
   logic [AW-1:0]    cnt;
   logic [WIDTH-1:0] q_0, q_1, rd_0, rd_1;
   logic             qv_0, qv_1, rv_0, rv_1, busy, werr, wr_ok, wr_drop;
   assign wr_ok   = (state == IDLE) && bus.io_WEN && !bus.io_CLR;
   assign wr_drop = bus.io_WEN && !wr_ok;
`ifdef NRAM_RF_WR_BYPASS_EN
   assign rd_0 = (wr_ok && bus.io_WADD == bus.io_RADD_0) ? bus.io_D : mem[bus.io_RADD_0];
   assign rd_1 = (wr_ok && bus.io_WADD == bus.io_RADD_1) ? bus.io_D : mem[bus.io_RADD_1];
   assign rv_0 = (wr_ok && bus.io_WADD == bus.io_RADD_0) || valid[bus.io_RADD_0];
   assign rv_1 = (wr_ok && bus.io_WADD == bus.io_RADD_1) || valid[bus.io_RADD_1];
`else
   assign rd_0 = mem[bus.io_RADD_0];
   assign rd_1 = mem[bus.io_RADD_1];
   assign rv_0 = valid[bus.io_RADD_0];
   assign rv_1 = valid[bus.io_RADD_1];
`endif
   assign bus.io_Q_0  = q_0;
   assign bus.io_Q_1  = q_1;
   assign bus.io_QV_0 = qv_0;
   assign bus.io_QV_1 = qv_1;
   assign bus.io_BUSY = busy;
   assign bus.io_WERR = werr;
   // Storage, clear sequencer and registered read/status outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         valid <= '0;
         cnt   <= '0;
         state <= IDLE;
         busy  <= 1'b0;
         werr  <= 1'b0;
         q_0   <= '0;
         q_1   <= '0;
         qv_0  <= 1'b0;
         qv_1  <= 1'b0;
      end else begin
         q_0  <= rd_0;
         q_1  <= rd_1;
         qv_0 <= rv_0;
         qv_1 <= rv_1;
         werr <= wr_drop;
         if (state == IDLE) begin
            if (bus.io_CLR) begin
               state <= CLEAR;
               cnt   <= '0;
               busy  <= 1'b1;
            end else if (wr_ok) begin
               mem[bus.io_WADD]   <= bus.io_D;
               valid[bus.io_WADD] <= 1'b1;
            end
         end else begin
            mem[cnt]   <= '0;
            valid[cnt] <= 1'b0;
            cnt        <= cnt + 1'b1;
            if (cnt == AW'(DEPTH - 1)) begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         end
      end
   end
endmodule
